morse_letter_sequencer: RTL and testbench
=========================================

Name: morse_letter_sequencer

Overview:
Sits directly downstream of button_input and sequences its per-press symbol stream into complete Morse letters. It detects button releases, captures the dot/dash classification one cycle later, and accumulates up to 5 symbols. On the letter-spacing flag it closes the letter, decodes it to ASCII, and pushes it into a small output FIFO with a valid/ready handshake. It also times long idle gaps and inserts word-space characters.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2
WORD_GAP, 7000, idle clk cycles after letter close, button low, before a space (0x20) is pushed
GAP_W, 32, width of the word-gap counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
button  input  1  raw button level, the same net that feeds button_input
morse_signal  input  2  from button_input: 2'b01 dash, 2'b10 dot, 2'b00 none/invalid
letter_spacing  input  1  from button_input; level, high after a letter gap
letter_valid  output  1  FIFO head valid
letter_ready  input  1  consumer accepts the head when letter_valid && letter_ready
letter_ascii  output  8  head: decoded ASCII character
letter_len  output  3  head: symbol count 0..5; 0 for a space
letter_bits  output  5  head: bit i = symbol i (1 = dash, 0 = dot), first symbol in bit 0; unused bits 0
letter_dropped  output  1  one-cycle pulse when a push is lost because the FIFO is full
overflow  output  1  one-cycle pulse when a 6th symbol is captured in one letter

Behaviour:
- Reset (async assert, sync release): state IDLE; symbol register, count, gap counter, FIFO pointers cleared. letter_valid=0, letter_ascii=0, letter_len=0, letter_bits=0, letter_dropped=0, overflow=0.
- Release detect: button_d is button registered. If button_d=1 and button=0 at edge k, set arm. At edge k+1 sample morse_signal and clear arm.
  - 2'b10: append a dot. 2'b01: append a dash. 2'b00 or 2'b11: ignore, no state change.
- Append: bits[cnt] <= symbol and cnt++ when cnt<5. When cnt==5, do not append; set bad flag and pulse overflow.
- Close detect: rising edge of letter_spacing (registered compare).
- States:
  - IDLE: on append -> COLLECT.
  - COLLECT: on close -> push letter, clear bits/cnt/bad, zero gap counter, -> GAP. If append and close occur on the same edge, append first; the closed letter includes that symbol.
  - GAP: counter increments each cycle while button=0. On counter == WORD_GAP-1 -> push space (ascii 0x20, len 0, bits 0) -> IDLE. Button=1 at any point -> IDLE with counter cleared; the release append then proceeds normally.
  - Close in IDLE or GAP is ignored.
- Decode (combinational on push): International Morse A–Z (0x41–0x5A) and 0–9 (0x30–0x39). Any unmatched pattern, or bad=1, gives 0x3F '?'. For bad letters the pushed len is 5 and the bits are the first 5 symbols.
- FIFO: push writes {ascii,len,bits}. Outputs are the head entry, registered; no combinational path from letter_ready to push.
  - Push with count==FIFO_DEPTH and no pop in the same cycle: drop the entry and pulse letter_dropped.
  - Simultaneous push and pop when full: both succeed, no drop.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - letter_valid = (count != 0). Head fields are held stable while letter_valid && !letter_ready.
- Latency: close edge to letter_valid is 2 cycles when the FIFO starts empty (1 cycle edge detect, 1 cycle push).
- Reset mid-letter or mid-gap discards the partial letter and all FIFO contents; no space is emitted afterwards.

Test Plan:
- Dot then dash (release captures morse_signal 2'b10, then 2'b01), then letter_spacing rise -> one entry: ascii 0x41 'A', len 2, bits 5'b00010; letter_valid 2 cycles after the rise.
- Five dots, then close -> 0x35 '5', len 5, bits 0. Six dots -> overflow pulse on the 6th capture; entry 0x3F, len 5.
- Letter 'E' (one dot) closed, button low for WORD_GAP cycles -> entries 'E' then 0x20 len 0. Pressing at cycle WORD_GAP-2 produces no space.
- letter_ready=0, FIFO_DEPTH=4, close 5 letters -> letter_dropped on the 5th. With letter_ready=1 held on the cycle a push occurs at count==4 -> no drop, count stays 4.
- Capture with morse_signal 2'b00 (short press) -> no append; state stays IDLE, and a following close pushes nothing.
- Assert rst_n=0 mid-COLLECT with 2 entries queued -> letter_valid=0 and all outputs 0 asynchronously; after release, a new 'T' (one dash) decodes to 0x54 with no stale symbols.

Source files
------------

// File: rtl/morse_letter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morse_letter_sequencer
// Purpose  : Groups per-press dot/dash symbols into letters, decodes them to
//            ASCII and queues letters and word spaces in a small output FIFO.
// Revision : 1.0  initial release
// ============================================================================
module morse_letter_sequencer #(
    parameter int FIFO_DEPTH = 4,     // power of 2, >= 2
    parameter int WORD_GAP   = 7000,
    parameter int GAP_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    input  logic [1:0] morse_signal,
    input  logic       letter_spacing,
    output logic       letter_valid,
    input  logic       letter_ready,
    output logic [7:0] letter_ascii,
    output logic [2:0] letter_len,
    output logic [4:0] letter_bits,
    output logic       letter_dropped,
    output logic       overflow
);

    localparam int               c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               c_CNT_W    = c_PTR_W + 1;
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(WORD_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       c_MAX_SYM  = 3'd5;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_GAP     = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               button_d_q, arm_q, ls_d_q, close_q;
    logic [4:0]         bits_q, bits_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               overflow_q, dropped_q;

    logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic               sym_valid, sym_dash, app_ok, app_ovf, bad_app;
    logic [4:0]         bits_app;
    logic [2:0]         cnt_app;
    logic               letter_push, space_push, push, pop, push_ok, drop;
    logic [15:0]        push_data;

    function automatic logic [7:0] f_decode(input logic [2:0] len, input logic [4:0] bits);
        logic [7:0] ch;
        case ({len, bits})
            {3'd1, 5'd0}:  ch = 8'h45;  {3'd1, 5'd1}:  ch = 8'h54;
            {3'd2, 5'd0}:  ch = 8'h49;  {3'd2, 5'd1}:  ch = 8'h4E;
            {3'd2, 5'd2}:  ch = 8'h41;  {3'd2, 5'd3}:  ch = 8'h4D;
            {3'd3, 5'd0}:  ch = 8'h53;  {3'd3, 5'd1}:  ch = 8'h44;
            {3'd3, 5'd2}:  ch = 8'h52;  {3'd3, 5'd3}:  ch = 8'h47;
            {3'd3, 5'd4}:  ch = 8'h55;  {3'd3, 5'd5}:  ch = 8'h4B;
            {3'd3, 5'd6}:  ch = 8'h57;  {3'd3, 5'd7}:  ch = 8'h4F;
            {3'd4, 5'd0}:  ch = 8'h48;  {3'd4, 5'd1}:  ch = 8'h42;
            {3'd4, 5'd2}:  ch = 8'h4C;  {3'd4, 5'd3}:  ch = 8'h5A;
            {3'd4, 5'd4}:  ch = 8'h46;  {3'd4, 5'd5}:  ch = 8'h43;
            {3'd4, 5'd6}:  ch = 8'h50;  {3'd4, 5'd8}:  ch = 8'h56;
            {3'd4, 5'd9}:  ch = 8'h58;  {3'd4, 5'd11}: ch = 8'h51;
            {3'd4, 5'd13}: ch = 8'h59;  {3'd4, 5'd14}: ch = 8'h4A;
            {3'd5, 5'd0}:  ch = 8'h35;  {3'd5, 5'd1}:  ch = 8'h36;
            {3'd5, 5'd3}:  ch = 8'h37;  {3'd5, 5'd7}:  ch = 8'h38;
            {3'd5, 5'd15}: ch = 8'h39;  {3'd5, 5'd16}: ch = 8'h34;
            {3'd5, 5'd24}: ch = 8'h33;  {3'd5, 5'd28}: ch = 8'h32;
            {3'd5, 5'd30}: ch = 8'h31;  {3'd5, 5'd31}: ch = 8'h30;
            default:       ch = 8'h3F;
        endcase
        return ch;
    endfunction

    // A release arms capture; morse_signal is valid one cycle after the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_d_q <= 1'b0;
            arm_q      <= 1'b0;
            ls_d_q     <= 1'b0;
            close_q    <= 1'b0;
        end else begin
            button_d_q <= button;
            arm_q      <= button_d_q & ~button;
            ls_d_q     <= letter_spacing;
            close_q    <= letter_spacing & ~ls_d_q;
        end
    end

    always_comb begin
        sym_valid = arm_q && (morse_signal == 2'b10 || morse_signal == 2'b01);
        sym_dash  = (morse_signal == 2'b01);
        app_ok    = sym_valid && (cnt_q < c_MAX_SYM);
        app_ovf   = sym_valid && (cnt_q == c_MAX_SYM);
        bits_app  = bits_q;
        if (app_ok) begin
            bits_app[cnt_q] = sym_dash;
        end
        cnt_app   = cnt_q + {2'b00, app_ok};
        bad_app   = bad_q | app_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:    if (sym_valid) state_d = c_ST_COLLECT;
            c_ST_COLLECT: if (close_q) state_d = c_ST_GAP;
            c_ST_GAP: begin
                if (sym_valid) begin
                    state_d = c_ST_COLLECT;
                end else if (button || (gap_q == c_GAP_LAST)) begin
                    state_d = c_ST_IDLE;
                end
            end
            default:      state_d = c_ST_IDLE;
        endcase
    end

    // Append always happens before close, so a same-edge symbol joins the letter.
    always_comb begin
        letter_push = 1'b0;
        space_push  = 1'b0;
        bits_d      = bits_app;
        cnt_d       = cnt_app;
        bad_d       = bad_app;
        gap_d       = '0;
        push_data   = {8'h20, 3'd0, 5'd0};
        case (state_q)
            c_ST_COLLECT: begin
                if (close_q) begin
                    letter_push = 1'b1;
                    push_data   = {(bad_app ? 8'h3F : f_decode(cnt_app, bits_app)), cnt_app, bits_app};
                    bits_d      = '0;
                    cnt_d       = '0;
                    bad_d       = 1'b0;
                end
            end
            c_ST_GAP: begin
                if (!sym_valid && !button) begin
                    if (gap_q == c_GAP_LAST) begin
                        space_push = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q     <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            bits_q     <= bits_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            gap_q      <= gap_d;
            overflow_q <= app_ovf;
            dropped_q  <= drop;
        end
    end

    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    always_comb begin
        push    = letter_push | space_push;
        pop     = letter_valid & letter_ready;
        push_ok = push && ((count_q != c_FULL) || pop);
        drop    = push && (count_q == c_FULL) && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            count_q <= count_q + c_CNT_W'(push_ok) - c_CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign letter_valid   = (count_q != '0);
    assign {letter_ascii, letter_len, letter_bits} = letter_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign letter_dropped = dropped_q;
    assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_letter_sequencer
// Purpose  : Directed and randomized bench with a queue-based letter model.
// Revision : 1.0  initial release
// ============================================================================
module tb_morse_letter_sequencer;

    localparam int DEPTH = 4;
    localparam int WG    = 50;
    localparam logic [1:0] DOT  = 2'b10;
    localparam logic [1:0] DASH = 2'b01;

    typedef struct packed {
        logic [7:0] ascii;
        logic [2:0] len;
        logic [4:0] bits;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b0;
    logic [1:0] morse_signal = 2'b00;
    logic       letter_spacing = 1'b0;
    logic       letter_ready = 1'b0;
    logic       letter_valid, letter_dropped, overflow;
    logic [7:0] letter_ascii;
    logic [2:0] letter_len;
    logic [4:0] letter_bits;

    int n_err = 0;
    int n_checks = 0;
    bit chk_en = 1'b0;
    int rdy_mode = 0;

    morse_letter_sequencer #(.FIFO_DEPTH(DEPTH), .WORD_GAP(WG), .GAP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .morse_signal(morse_signal),
        .letter_spacing(letter_spacing), .letter_valid(letter_valid),
        .letter_ready(letter_ready), .letter_ascii(letter_ascii),
        .letter_len(letter_len), .letter_bits(letter_bits),
        .letter_dropped(letter_dropped), .overflow(overflow)
    );

    always #5 clk = ~clk;

    string MTAB [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                         "--...", "---..", "----."};
    string CHARS = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    // Letter entry from the full list of captured symbols (true = dash).
    function automatic ent_t mk_entry(input bit s[$]);
        ent_t e;
        string p;
        int n;
        n = s.size();
        p = "";
        e.bits = '0;
        for (int i = 0; i < n && i < 5; i++) begin
            if (s[i]) p = {p, "-"};
            else      p = {p, "."};
            e.bits[i] = s[i];
        end
        e.len = (n > 5) ? 3'd5 : 3'(n);
        e.ascii = 8'h3F;
        if (n <= 5) begin
            for (int i = 0; i < 36; i++) if (MTAB[i] == p) e.ascii = CHARS[i];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t mq[$];
    bit   m_syms[$];
    bit   m_prev_btn, m_prev_ls, m_cap_pend, m_close_pend, m_gap;
    int   m_idle;
    bit   e_ovf, e_drop;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete(); m_syms.delete();
            m_prev_btn = 0; m_prev_ls = 0; m_cap_pend = 0; m_close_pend = 0;
            m_gap = 0; m_idle = 0; e_ovf = 0; e_drop = 0;
        end else begin
            bit symv, dsh, pop, have_push;
            ent_t pe;
            symv = m_cap_pend && (morse_signal == DOT || morse_signal == DASH);
            dsh  = (morse_signal == DASH);
            pop  = (mq.size() != 0) && letter_ready;
            have_push = 0;
            pe = '0;
            e_ovf = 0;
            if (m_gap) begin
                if (symv) begin
                    m_syms.push_back(dsh);
                    m_gap = 0;
                end else if (button) begin
                    m_gap = 0;
                end else if (m_idle == WG - 1) begin
                    have_push = 1; pe.ascii = 8'h20; m_gap = 0;
                end else begin
                    m_idle++;
                end
            end else begin
                if (symv) begin
                    if (m_syms.size() >= 5) e_ovf = 1;
                    m_syms.push_back(dsh);
                end
                if (m_close_pend && m_syms.size() != 0) begin
                    pe = mk_entry(m_syms);
                    have_push = 1;
                    m_syms.delete();
                    m_gap = 1;
                    m_idle = 0;
                end
            end
            e_drop = have_push && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (have_push && !e_drop) mq.push_back(pe);
            m_cap_pend   = m_prev_btn && !button;
            m_prev_btn   = button;
            m_close_pend = letter_spacing && !m_prev_ls;
            m_prev_ls    = letter_spacing;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n === 1'b1) begin
            chk("cyc_valid", 32'(letter_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("cyc_ascii", 32'(letter_ascii), 32'(mq[0].ascii));
                chk("cyc_len",   32'(letter_len),   32'(mq[0].len));
                chk("cyc_bits",  32'(letter_bits),  32'(mq[0].bits));
            end
            chk("cyc_dropped",  32'(letter_dropped), 32'(e_drop));
            chk("cyc_overflow", 32'(overflow),       32'(e_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) letter_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input int dur, input logic [1:0] sig, output logic ovf);
        button = 1'b1;
        tick(dur);
        button = 1'b0;
        morse_signal = sig;
        tick(2);
        ovf = overflow;
        morse_signal = 2'b00;
        tick(1);
    endtask

    task automatic close_letter(output logic drop);
        letter_spacing = 1'b1;
        tick(2);
        drop = letter_dropped;
        letter_spacing = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        letter_ready = 1'b1;
        tick(1);
        letter_ready = 1'b0;
    endtask

    task automatic flush();
        int i;
        tick(WG + 5);
        letter_ready = 1'b1;
        i = 0;
        while (letter_valid && i < 4 * DEPTH) begin
            tick(1);
            i++;
        end
        letter_ready = 1'b0;
        chk("flush_empty", 32'(letter_valid), 32'd0);
    endtask

    task automatic chk_head(input string nm, input logic [7:0] a, input logic [2:0] l, input logic [4:0] b);
        chk({nm, "_valid"}, 32'(letter_valid), 32'd1);
        chk({nm, "_ascii"}, 32'(letter_ascii), 32'(a));
        chk({nm, "_len"},   32'(letter_len),   32'(l));
        chk({nm, "_bits"},  32'(letter_bits),  32'(b));
    endtask

    initial begin
        logic ov, dr;
        bit q[$];
        ent_t e;
        int n;

        // Model pins
        q = '{0, 1};
        e = mk_entry(q);
        chk("pin_A_ascii", 32'(e.ascii), 32'h41);
        chk("pin_A_bits",  32'(e.bits),  32'h02);
        q = '{1, 1, 1, 1, 1};
        e = mk_entry(q);
        chk("pin_0_ascii", 32'(e.ascii), 32'h30);
        chk("pin_0_bits",  32'(e.bits),  32'h1F);
        q = '{0, 0, 0, 0, 0, 0};
        e = mk_entry(q);
        chk("pin_bad_ascii", 32'(e.ascii), 32'h3F);
        chk("pin_bad_len",   32'(e.len),   32'd5);
        q = '{1, 1, 1, 1};
        e = mk_entry(q);
        chk("pin_unmatched", 32'(e.ascii), 32'h3F);

        // Reset state
        tick(3);
        chk("rst_valid",    32'(letter_valid),   32'd0);
        chk("rst_ascii",    32'(letter_ascii),   32'd0);
        chk("rst_len",      32'(letter_len),     32'd0);
        chk("rst_bits",     32'(letter_bits),    32'd0);
        chk("rst_dropped",  32'(letter_dropped), 32'd0);
        chk("rst_overflow", 32'(overflow),       32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // 'A' with latency
        press(3, DOT, ov);
        press(3, DASH, ov);
        letter_spacing = 1'b1;
        tick(1);
        chk("A_lat1", 32'(letter_valid), 32'd0);
        tick(1);
        chk_head("A", 8'h41, 3'd2, 5'b00010);
        letter_spacing = 1'b0;
        tick(1);
        pop_one();
        flush();

        // Five dots -> '5'
        for (int i = 0; i < 5; i++) press(2, DOT, ov);
        close_letter(dr);
        chk_head("five", 8'h35, 3'd5, 5'd0);
        flush();

        // Six dots -> overflow on 6th, '?'
        for (int i = 0; i < 6; i++) begin
            press(2, DOT, ov);
            if (i >= 4) chk("six_ovf", 32'(ov), 32'(i == 5));
        end
        close_letter(dr);
        chk_head("six", 8'h3F, 3'd5, 5'd0);
        flush();

        // 'E' then word space
        press(2, DOT, ov);
        close_letter(dr);
        tick(WG + 2);
        chk_head("E1", 8'h45, 3'd1, 5'd0);
        pop_one();
        chk_head("space", 8'h20, 3'd0, 5'd0);
        flush();

        // Press at gap cycle WG-2 suppresses the space
        press(2, DOT, ov);
        close_letter(dr);
        tick(WG - 4);
        press(2, DASH, ov);
        close_letter(dr);
        chk_head("E2", 8'h45, 3'd1, 5'd0);
        pop_one();
        chk_head("T_nospace", 8'h54, 3'd1, 5'd1);
        flush();

        // Invalid captures append nothing
        press(3, 2'b00, ov);
        press(3, 2'b11, ov);
        close_letter(dr);
        chk("invalid_nopush", 32'(letter_valid), 32'd0);
        flush();

        // FIFO full: 5th letter dropped; push with pop while full succeeds
        for (int i = 0; i < 5; i++) begin
            press(2, DOT, ov);
            close_letter(dr);
            chk("drop_flag", 32'(dr), 32'(i == 4));
        end
        press(2, DASH, ov);
        letter_spacing = 1'b1;
        tick(1);
        letter_ready = 1'b1;
        tick(1);
        chk("full_pushpop_nodrop", 32'(letter_dropped), 32'd0);
        letter_ready = 1'b0;
        letter_spacing = 1'b0;
        tick(1);
        letter_ready = 1'b1;
        n = 0;
        while (letter_valid && n < 10) begin
            tick(1);
            n++;
        end
        letter_ready = 1'b0;
        chk("full_count", 32'(n), 32'd4);
        flush();

        // Asynchronous reset mid-letter with entries queued
        press(2, DOT, ov);
        close_letter(dr);
        press(2, DASH, ov);
        close_letter(dr);
        press(2, DOT, ov);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid",    32'(letter_valid),   32'd0);
        chk("arst_ascii",    32'(letter_ascii),   32'd0);
        chk("arst_len",      32'(letter_len),     32'd0);
        chk("arst_bits",     32'(letter_bits),    32'd0);
        chk("arst_dropped",  32'(letter_dropped), 32'd0);
        chk("arst_overflow", 32'(overflow),       32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        press(2, DASH, ov);
        close_letter(dr);
        chk_head("T_after_rst", 8'h54, 3'd1, 5'd1);
        flush();

        // Randomized letters, gaps and consumer back-pressure
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int ns;
            ns = $urandom_range(0, 7);
            for (int j = 0; j < ns; j++) begin
                int r;
                logic [1:0] sg;
                r = $urandom_range(0, 9);
                sg = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? DOT : DASH;
                press($urandom_range(1, 4), sg, ov);
                tick($urandom_range(0, 2));
            end
            close_letter(dr);
            if ($urandom_range(0, 3) == 0) tick(WG + $urandom_range(0, 5));
            else tick($urandom_range(2, 20));
        end
        rdy_mode = 0;
        flush();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
